// File: rtl/fsm_stim_pkg.sv
// Shared definitions for the Mealy-controller stimulus driver: state
// encoding, pin bit positions and the default idle stimulus vector.
package fsm_stim_pkg;

  // Driver FSM state encoding (2-bit, kept as plain constants for legacy tools)
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRIVE = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;

  // Bit positions inside the packed {A0,A4,I3} stimulus vector
  localparam int VEC_A0 = 2;
  localparam int VEC_A4 = 1;
  localparam int VEC_I3 = 0;

  // Bit positions inside the packed {U4,U8,O3} response vector
  localparam int RSP_U4 = 2;
  localparam int RSP_U8 = 1;
  localparam int RSP_O3 = 0;

  // Stimulus applied to the controller whenever no command is in flight
  localparam logic [2:0] IDLE_VEC_DEFAULT = 3'b000;

endpackage

// File: rtl/fsm_stim_if.sv
// Command and response handshakes of the stimulus driver. The master side
// issues commands and consumes summaries; the slave side is the driver.
interface fsm_stim_if #(
  parameter int REP_W = 4
) ();

  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_vec;
  logic [REP_W-1:0] cmd_len;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [2:0]       rsp_or;
  logic [2:0]       rsp_last;
  logic [REP_W:0]   rsp_hits;

  modport master (
    output cmd_valid, cmd_vec, cmd_len, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_or, rsp_last, rsp_hits
  );

  modport slave (
    input  cmd_valid, cmd_vec, cmd_len, rsp_ready,
    output cmd_ready, rsp_valid, rsp_or, rsp_last, rsp_hits
  );

endinterface

// File: rtl/fsm_stim_acc.sv
// Response accumulator: ORs every sampled controller output, keeps the most
// recent sample, and counts samples with any output bit high.
module fsm_stim_acc #(
  parameter int REP_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [2:0]       sample_i,
  output logic [2:0]       or_o,
  output logic [2:0]       last_o,
  output logic [REP_W:0]   hits_o
);

  // One extra bit holds the full 2^REP_W count, so no saturation is needed
  localparam logic [REP_W:0] HIT_ONE = 1;

  logic [2:0]     or_q,   or_d;
  logic [2:0]     last_q, last_d;
  logic [REP_W:0] hits_q, hits_d;

  // Next-state: clear wins over enable; otherwise fold in the current sample
  always_comb begin
    or_d   = or_q;
    last_d = last_q;
    hits_d = hits_q;
    if (clr_i) begin
      or_d   = '0;
      last_d = '0;
      hits_d = '0;
    end else if (en_i) begin
      or_d   = or_q | sample_i;
      last_d = sample_i;
      if (|sample_i) begin
        hits_d = hits_q + HIT_ONE;
      end
    end
  end

  // Accumulator registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      or_q   <= '0;
      last_q <= '0;
      hits_q <= '0;
    end else begin
      or_q   <= or_d;
      last_q <= last_d;
      hits_q <= hits_d;
    end
  end

  assign or_o   = or_q;
  assign last_o = last_q;
  assign hits_o = hits_q;

endmodule

// File: rtl/fsm_stim_driver.sv
// Command-driven stimulus transmitter for the 6-state Mealy controller.
// Drives a latched {A0,A4,I3} vector for cmd_len+1 cycles, collects the
// {U4,U8,O3} response and hands back one summary per command.
module fsm_stim_driver
  import fsm_stim_pkg::*;
#(
  parameter int         REP_W    = 4,
  parameter logic [2:0] IDLE_VEC = IDLE_VEC_DEFAULT
) (
  input  logic      clk,
  input  logic      rst,
  fsm_stim_if.slave bus,
  output logic      A0,
  output logic      A4,
  output logic      I3,
  input  logic      U4,
  input  logic      U8,
  input  logic      O3
);

  localparam logic [REP_W-1:0] CNT_ONE = 1;

  logic [1:0]       state_q, state_d;
  logic [REP_W-1:0] cnt_q, cnt_d;
  logic [2:0]       pins_q, pins_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             acc_clr;
  logic             acc_en;
  logic [2:0]       sample;

  // Pack the controller outputs into the {U4,U8,O3} ordering
  always_comb begin
    sample         = '0;
    sample[RSP_U4] = U4;
    sample[RSP_U8] = U8;
    sample[RSP_O3] = O3;
  end

  // FSM next-state; the pin register doubles as the latched command vector
  // and every output is computed one cycle ahead so all of them are flops
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pins_d      = pins_q;
    cmd_ready_d = cmd_ready_q;
    rsp_valid_d = rsp_valid_q;
    acc_clr     = 1'b0;
    acc_en      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid && cmd_ready_q) begin
          state_d     = ST_DRIVE;
          cnt_d       = bus.cmd_len;
          pins_d      = bus.cmd_vec;
          cmd_ready_d = 1'b0;
          acc_clr     = 1'b1;
        end
      end
      ST_DRIVE: begin
        acc_en = 1'b1;
        if (cnt_q == '0) begin
          state_d     = ST_RESP;
          pins_d      = IDLE_VEC;
          rsp_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        pins_d      = IDLE_VEC;
        cmd_ready_d = 1'b1;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  // State, counter and output registers; reset discards any in-flight command
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      pins_q      <= IDLE_VEC;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pins_q      <= pins_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  fsm_stim_acc #(
    .REP_W (REP_W)
  ) u_acc (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (acc_clr),
    .en_i     (acc_en),
    .sample_i (sample),
    .or_o     (bus.rsp_or),
    .last_o   (bus.rsp_last),
    .hits_o   (bus.rsp_hits)
  );

  assign A0            = pins_q[VEC_A0];
  assign A4            = pins_q[VEC_A4];
  assign I3            = pins_q[VEC_I3];
  assign bus.cmd_ready = cmd_ready_q;
  assign bus.rsp_valid = rsp_valid_q;

endmodule

// File: tb/tb_fsm_stim_driver.sv
// Directed testbench for fsm_stim_driver. Commands push their expected
// summary into a scoreboard queue; an independent monitor checks each
// response against the queue head while it is presented.
module tb_fsm_stim_driver;
  import fsm_stim_pkg::*;

  localparam int REP_W = 4;

  typedef struct {
    logic [2:0]     orVal;
    logic [2:0]     lastVal;
    logic [REP_W:0] hits;
    int             firstCycle;
  } rsp_t;

  logic clk = 1'b0;
  logic rst;
  logic A0, A4, I3;
  logic U4, U8, O3;
  logic [2:0] pins;

  int checkCount = 0;
  int errorCount = 0;
  int cycleCount = 0;
  rsp_t sbQ[$];
  rsp_t expRsp;
  bit prevValid = 1'b0;

  fsm_stim_if #(.REP_W(REP_W)) bus ();

  fsm_stim_driver #(
    .REP_W    (REP_W),
    .IDLE_VEC (3'b000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .A0  (A0),
    .A4  (A4),
    .I3  (I3),
    .U4  (U4),
    .U8  (U8),
    .O3  (O3)
  );

  assign pins = {A0, A4, I3};

  // Free-running clock
  always #5 clk = ~clk;

  // Count rising edges so latencies can be expressed in cycles
  always @(posedge clk) cycleCount <= cycleCount + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Issue one command, drive the controller outputs during its window, and
  // queue the hand-computed summary. U follows uA on even drive cycles and
  // uB on odd ones; outside the window U is held at 111 as noise.
  task automatic applyStimulus(input logic [2:0] vec, input logic [REP_W-1:0] len,
                               input logic [2:0] uA, input logic [2:0] uB,
                               input logic [2:0] expOr, input logic [2:0] expLast,
                               input logic [REP_W:0] expHits, output int acceptCount);
    bit accepted;
    rsp_t e;
    acceptCount = -1;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_vec   = vec;
    bus.cmd_len   = len;
    accepted = 1'b0;
    for (int w = 0; w < 64 && !accepted; w++) begin
      accepted = (bus.cmd_ready === 1'b1);
      @(negedge clk);
    end
    bus.cmd_valid = 1'b0;
    if (!accepted) begin
      checkOutput("cmd accept timeout", 32'd0, 32'd1);
      return;
    end
    acceptCount  = cycleCount;
    e.orVal      = expOr;
    e.lastVal    = expLast;
    e.hits       = expHits;
    e.firstCycle = acceptCount + int'(len) + 1;
    sbQ.push_back(e);
    for (int j = 0; j <= int'(len); j++) begin
      {U4, U8, O3} = (j % 2 == 0) ? uA : uB;
      checkOutput("drive pins", pins, vec);
      checkOutput("cmd_ready in DRIVE", bus.cmd_ready, 1'b0);
      @(negedge clk);
    end
    {U4, U8, O3} = 3'b111;
    checkOutput("pins after drive", pins, 3'b000);
    checkOutput("rsp_valid after drive", bus.rsp_valid, 1'b1);
  endtask

  // Scoreboard monitor: compares every presented response to the queue head
  always begin
    @(negedge clk);
    #1;
    if (bus.rsp_valid === 1'b1) begin
      if (sbQ.size() == 0) begin
        checkOutput("unexpected rsp_valid", bus.rsp_valid, 1'b0);
      end else begin
        expRsp = sbQ[0];
        if (!prevValid) begin
          checkOutput("rsp latency", cycleCount, expRsp.firstCycle);
        end
        checkOutput("rsp_or", bus.rsp_or, expRsp.orVal);
        checkOutput("rsp_last", bus.rsp_last, expRsp.lastVal);
        checkOutput("rsp_hits", bus.rsp_hits, expRsp.hits);
        if (bus.rsp_ready === 1'b1) begin
          void'(sbQ.pop_front());
        end
      end
    end
    prevValid = (bus.rsp_valid === 1'b1) && (bus.rsp_ready !== 1'b1);
  end

  // Safety net so the run always terminates
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed test sequence
  initial begin
    int acc;
    int acc2;
    int mark;
    bus.cmd_valid = 1'b0;
    bus.cmd_vec   = 3'b000;
    bus.cmd_len   = '0;
    bus.rsp_ready = 1'b1;
    {U4, U8, O3}  = 3'b111;
    rst           = 1'b1;

    // Reset held for two edges
    repeat (2) @(negedge clk);
    checkOutput("reset pins", pins, 3'b000);
    checkOutput("reset cmd_ready", bus.cmd_ready, 1'b1);
    checkOutput("reset rsp_valid", bus.rsp_valid, 1'b0);
    checkOutput("reset rsp_or", bus.rsp_or, 3'b000);
    checkOutput("reset rsp_last", bus.rsp_last, 3'b000);
    checkOutput("reset rsp_hits", bus.rsp_hits, 5'd0);
    rst = 1'b0;

    $display("[TB] basic command");
    applyStimulus(3'b101, 4'd2, 3'b010, 3'b010, 3'b010, 3'b010, 5'd3, acc);

    $display("[TB] minimum length");
    applyStimulus(3'b110, 4'd0, 3'b000, 3'b000, 3'b000, 3'b000, 5'd0, acc);

    $display("[TB] mixed response pattern");
    applyStimulus(3'b011, 4'd3, 3'b001, 3'b100, 3'b101, 3'b100, 5'd4, acc);
    applyStimulus(3'b001, 4'd1, 3'b000, 3'b010, 3'b010, 3'b010, 5'd1, acc);

    $display("[TB] backpressure");
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    applyStimulus(3'b100, 4'd1, 3'b001, 3'b001, 3'b001, 3'b001, 5'd2, acc);
    bus.cmd_valid = 1'b1;
    bus.cmd_vec   = 3'b010;
    bus.cmd_len   = 4'd0;
    for (int i = 0; i < 5; i++) begin
      checkOutput("stall cmd_ready", bus.cmd_ready, 1'b0);
      checkOutput("stall pins", pins, 3'b000);
      checkOutput("stall rsp_valid", bus.rsp_valid, 1'b1);
      @(negedge clk);
    end
    mark = cycleCount;
    bus.rsp_ready = 1'b1;
    applyStimulus(3'b010, 4'd0, 3'b100, 3'b100, 3'b100, 3'b100, 5'd1, acc2);
    checkOutput("accept after release", acc2, mark + 2);

    $display("[TB] reset during drive");
    @(negedge clk);
    checkOutput("idle before abort", bus.cmd_ready, 1'b1);
    bus.cmd_valid = 1'b1;
    bus.cmd_vec   = 3'b111;
    bus.cmd_len   = 4'd5;
    {U4, U8, O3}  = 3'b010;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    checkOutput("abort drive cycle 1", pins, 3'b111);
    @(negedge clk);
    checkOutput("abort drive cycle 2", pins, 3'b111);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort pins", pins, 3'b000);
    checkOutput("abort cmd_ready", bus.cmd_ready, 1'b1);
    checkOutput("abort rsp_valid", bus.rsp_valid, 1'b0);
    checkOutput("abort rsp_hits", bus.rsp_hits, 5'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("no rsp after abort", bus.rsp_valid, 1'b0);
    end
    {U4, U8, O3} = 3'b111;

    $display("[TB] maximum length");
    applyStimulus(3'b011, 4'd15, 3'b100, 3'b000, 3'b100, 3'b000, 5'd8, acc);

    // Let the last response drain through the monitor
    for (int i = 0; i < 20 && sbQ.size() != 0; i++) begin
      @(negedge clk);
    end
    @(negedge clk);
    checkOutput("scoreboard drained", sbQ.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/fsm_stim_driver.md
# fsm_stim_driver

Command-driven stimulus transmitter for the 6-state Mealy controller (inputs A0/A4/I3, outputs U4/U8/O3). It accepts input-vector commands over a valid/ready handshake and drives that vector onto the controller's A0/A4/I3 pins for a programmed number of cycles. While driving, it collects the controller's U4/U8/O3 response and returns one summary per command over a second valid/ready handshake.

## Interface
- REP_W, 4, width of the repeat field; a command drives for cmd_len+1 cycles (1..2^REP_W)
- IDLE_VEC, 3'b000, {A0,A4,I3} value driven whenever no command is active

- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  driver can accept a command
- cmd_vec  in  3  {A0,A4,I3} to drive
- cmd_len  in  REP_W  drive length minus one
- A0, A4, I3  out  1 each  stimulus to the controller
- U4, U8, O3  in  1 each  controller outputs, same-cycle (Mealy)
- rsp_valid  out  1  summary available
- rsp_ready  in  1  consumer takes summary
- rsp_or  out  3  {U4,U8,O3} OR-accumulated over the drive window
- rsp_last  out  3  {U4,U8,O3} sampled in the final drive cycle
- rsp_hits  out  REP_W+1  count of drive cycles with any of U4/U8/O3 high

## Operation
- States are IDLE, DRIVE and RESP.
- IDLE
  - cmd_ready=1; pins=IDLE_VEC.
  - On cmd_valid&cmd_ready: latch cmd_vec, load cnt=cmd_len, clear the accumulators, go to DRIVE.
- DRIVE
  - cmd_ready=0; pins=latched vec.
  - Each cycle: sample {U4,U8,O3}, OR it into rsp_or, store it to rsp_last, and increment rsp_hits if the sample is nonzero.
  - If cnt==0, go to RESP; else cnt-1.
- RESP
  - rsp_valid=1; pins=IDLE_VEC; cmd_ready=0.
  - rsp_* stay stable until rsp_valid&rsp_ready, then go to IDLE.
- Width rule: rsp_hits ≤ 2^REP_W, so REP_W+1 bits cannot overflow. No saturation logic is needed.
- cmd_valid in DRIVE or RESP is ignored. The command is neither consumed nor buffered; the source must hold it.
- No combinational path exists from U4/U8/O3 or rsp_ready to any output. All outputs are registered.

## Timing
- Reset value of every output is applied in the cycle after rst is sampled high:
  - pins=IDLE_VEC, cmd_ready=1, rsp_valid=0
  - rsp_or=0, rsp_last=0, rsp_hits=0
- Command accepted at edge k:
  - Pins carry the vec in cycles k+1 … k+1+cmd_len.
  - U4/U8/O3 are sampled at the end of each of those cycles.
- rsp_valid rises in cycle k+cmd_len+2, so accept-to-response latency is cmd_len+2 cycles.
- Response taken at edge m: IDLE and cmd_ready=1 from cycle m+1. Minimum command-to-command spacing is cmd_len+3 cycles.
- Reset mid-operation (DRIVE or RESP): the in-flight command and any pending response are discarded, and the reset values apply from the next cycle. No rsp_valid is emitted for the aborted command.
- rst has priority over every handshake in the same cycle.

## Structure
- Package fsm_stim_pkg holds:
  - the state encoding (IDLE=0, DRIVE=1, RESP=2, 2-bit)
  - bit-index localparams for the {A0,A4,I3} and {U4,U8,O3} orderings
  - the default IDLE_VEC
- Sub-module fsm_stim_acc holds the response accumulator: OR, last, and hit counter, with clear/enable inputs.
- The top holds the FSM, the repeat counter and the handshakes.

## Test plan
- Reset: rst=1 for 2 cycles, then 0 → A0/A4/I3=000, cmd_ready=1, rsp_valid=0, rsp_*=0.
- Basic command: cmd_vec=3'b101, cmd_len=2, bench holds {U4,U8,O3}=010 → pins 101 for exactly 3 cycles, then 000; rsp_valid at accept+4 with rsp_or=010, rsp_last=010, rsp_hits=3.
- Minimum length: cmd_len=0, U=000 → pins driven for 1 cycle; rsp_valid at accept+2 with rsp_or=000, rsp_hits=0.
- Backpressure: rsp_ready=0 for 5 cycles and cmd_valid held high → rsp_valid and rsp_* stable, cmd_ready=0, pins=000, second command not accepted until 1 cycle after rsp_ready.
- Reset during DRIVE (cycle 2 of cmd_len=5) → next cycle pins=000, cmd_ready=1; no rsp_valid ever for that command.
- Max length: cmd_len=15 (REP_W=4), U alternates 100/000 starting with 100 → 16 drive cycles, rsp_hits=8, rsp_or=100, rsp_last=000.
